// File: rtl/mbi_phase_sel_ctrl_if.sv
// Request/config/status bundle between the phase-select controller and its requester.
// The controller takes the slave modport; the requester or stimulus side takes master.
interface mbi_phase_sel_ctrl_if #(
  parameter int unsigned DWELL_WIDTH = 16
);
  logic [1:0]             PHASE_REQ;
  logic                   PHASE_REQ_VALID;
  logic                   PHASE_REQ_READY;
  logic                   SWEEP_EN;
  logic [DWELL_WIDTH-1:0] DWELL_CYCLES;
  logic                   CLK_MOD_PHASE_SEL1;
  logic                   CLK_MOD_PHASE_SEL2;
  logic                   CLK_MOD_EN;
  logic [1:0]             PHASE_CUR;
  logic                   SWITCH_DONE;

  modport master (
    output PHASE_REQ,
    output PHASE_REQ_VALID,
    output SWEEP_EN,
    output DWELL_CYCLES,
    input  PHASE_REQ_READY,
    input  CLK_MOD_PHASE_SEL1,
    input  CLK_MOD_PHASE_SEL2,
    input  CLK_MOD_EN,
    input  PHASE_CUR,
    input  SWITCH_DONE
  );

  modport slave (
    input  PHASE_REQ,
    input  PHASE_REQ_VALID,
    input  SWEEP_EN,
    input  DWELL_CYCLES,
    output PHASE_REQ_READY,
    output CLK_MOD_PHASE_SEL1,
    output CLK_MOD_PHASE_SEL2,
    output CLK_MOD_EN,
    output PHASE_CUR,
    output SWITCH_DONE
  );
endinterface

// File: rtl/mbi_phase_sel_ctrl.sv
// Modulation-clock phase mux select controller: sequences every phase change as
// gate -> switch -> settle -> ungate, driven by handshake requests or an auto sweep.
module mbi_phase_sel_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned DWELL_WIDTH   = 16
) (
  input  logic                       USER_CLOCK,
  input  logic                       RST,
  mbi_phase_sel_ctrl_if.slave        bus
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_SWITCH,
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             phase_q, phase_d;
  logic [1:0]             target_q, target_d;
  logic [CW-1:0]          settle_q, settle_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic                   en_q, en_d;
  logic                   rdy_q, rdy_d;
  logic                   done_q, done_d;

  logic accept;
  logic sweep_on;
  logic sweep_step;

  assign accept     = bus.PHASE_REQ_VALID && (state_q == S_IDLE);
  assign sweep_on   = bus.SWEEP_EN && (bus.DWELL_CYCLES != '0);
  assign sweep_step = sweep_on && (dwell_q == (bus.DWELL_CYCLES - DWELL_WIDTH'(1)));

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    target_d = target_q;
    settle_d = settle_q;
    dwell_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        // An explicit request outranks a coincident sweep step; dwell restarts either way.
        if (accept) begin
          if (bus.PHASE_REQ != phase_q) begin
            target_d = bus.PHASE_REQ;
            settle_d = '0;
            state_d  = S_GATE;
          end else begin
            state_d  = S_DONE;
          end
        end else if (sweep_step) begin
          target_d = phase_q + 2'd1;
          settle_d = '0;
          state_d  = S_GATE;
        end else if (sweep_on) begin
          dwell_d  = dwell_q + DWELL_WIDTH'(1);
        end
      end

      S_GATE: begin
        if (settle_q == SETTLE_LAST) begin
          phase_d  = target_q;
          settle_d = '0;
          state_d  = S_SWITCH;
        end else begin
          settle_d = settle_q + CW'(1);
        end
      end

      S_SWITCH: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = S_DONE;
        end else begin
          settle_d = settle_q + CW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered off the next state so they change with it.
    en_d   = !((state_d == S_GATE) || (state_d == S_SWITCH));
    rdy_d  = (state_d == S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge USER_CLOCK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      target_q <= '0;
      settle_q <= '0;
      dwell_q  <= '0;
      en_q     <= 1'b1;
      rdy_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      target_q <= target_d;
      settle_q <= settle_d;
      dwell_q  <= dwell_d;
      en_q     <= en_d;
      rdy_q    <= rdy_d;
      done_q   <= done_d;
    end
  end

  assign bus.CLK_MOD_PHASE_SEL1 = phase_q[0];
  assign bus.CLK_MOD_PHASE_SEL2 = phase_q[1];
  assign bus.PHASE_CUR          = phase_q;
  assign bus.CLK_MOD_EN         = en_q;
  assign bus.PHASE_REQ_READY    = rdy_q;
  assign bus.SWITCH_DONE        = done_q;

endmodule

// File: tb/tb_mbi_phase_sel_ctrl.sv
// Bench for mbi_phase_sel_ctrl: directed scenarios then random traffic, checked each
// cycle against a timeline model of when each phase change gates, switches and completes.
module tb_mbi_phase_sel_ctrl;

  localparam int S  = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mbi_phase_sel_ctrl_if #(.DWELL_WIDTH(DW)) bus ();

  mbi_phase_sel_ctrl #(
    .SETTLE_CYCLES(S),
    .DWELL_WIDTH  (DW)
  ) dut (
    .USER_CLOCK(clk),
    .RST       (rst),
    .bus       (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Model: the last accepted operation and its acceptance cycle define every output.
  bit         have_op = 0;
  bit         op_real = 0;
  int         op_t    = 0;
  logic [1:0] op_old  = 2'd0;
  logic [1:0] op_new  = 2'd0;
  logic [1:0] cur_ph  = 2'd0;
  int         run     = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
  endtask

  function automatic void expect_at(input int c, output bit en, output bit rdy,
                                    output bit dn, output logic [1:0] ph);
    int d;
    en = 1'b1; rdy = 1'b1; dn = 1'b0; ph = cur_ph;
    if (have_op) begin
      d = c - op_t;
      if (op_real) begin
        en  = !(d >= 1 && d <= 2 * S);
        dn  = (d == 2 * S + 1);
        rdy = (d >= 2 * S + 2);
        ph  = (d >= S + 1) ? op_new : op_old;
      end else begin
        dn  = (d == 1);
        rdy = (d >= 2);
      end
    end
  endfunction

  function automatic void start_op(input logic [1:0] nph);
    have_op = 1'b1;
    op_t    = cyc;
    op_old  = cur_ph;
    op_new  = nph;
    op_real = (nph != cur_ph);
    cur_ph  = nph;
  endfunction

  function automatic void model_edge();
    bit en, rdy, dn;
    logic [1:0] ph;
    expect_at(cyc, en, rdy, dn, ph);
    if (rst) begin
      have_op = 1'b0;
      cur_ph  = 2'd0;
      run     = 0;
    end else if (rdy) begin
      if (bus.PHASE_REQ_VALID) begin
        start_op(bus.PHASE_REQ);
        run = 0;
      end else if (bus.SWEEP_EN && bus.DWELL_CYCLES != '0) begin
        run++;
        if (run == int'(bus.DWELL_CYCLES)) begin
          start_op(2'(cur_ph + 2'd1));
          run = 0;
        end
      end else begin
        run = 0;
      end
    end else begin
      run = 0;
    end
  endfunction

  task automatic check_outputs();
    bit en, rdy, dn;
    logic [1:0] ph;
    expect_at(cyc, en, rdy, dn, ph);
    chk("clk_mod_en",  16'(bus.CLK_MOD_EN),         16'(en));
    chk("ready",       16'(bus.PHASE_REQ_READY),    16'(rdy));
    chk("switch_done", 16'(bus.SWITCH_DONE),        16'(dn));
    chk("phase_cur",   16'(bus.PHASE_CUR),          16'(ph));
    chk("sel1",        16'(bus.CLK_MOD_PHASE_SEL1), 16'(ph[0]));
    chk("sel2",        16'(bus.CLK_MOD_PHASE_SEL2), 16'(ph[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    cyc++;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic request(input logic [1:0] ph);
    bus.PHASE_REQ       = ph;
    bus.PHASE_REQ_VALID = 1'b1;
    tick();
    bus.PHASE_REQ_VALID = 1'b0;
  endtask

  initial begin
    int t0;
    rst                 = 1'b1;
    bus.PHASE_REQ       = 2'd0;
    bus.PHASE_REQ_VALID = 1'b0;
    bus.SWEEP_EN        = 1'b0;
    bus.DWELL_CYCLES    = '0;

    ticks(2);
    chk("reset_en",    16'(bus.CLK_MOD_EN), 16'd1);
    chk("reset_ready", 16'(bus.PHASE_REQ_READY), 16'd1);
    chk("reset_phase", 16'(bus.PHASE_CUR), 16'd0);
    rst = 1'b0;
    ticks(3);

    // Same-phase request: no gating, done on the following cycle.
    request(2'd0);
    chk("same_done", 16'(bus.SWITCH_DONE), 16'd1);
    chk("same_en",   16'(bus.CLK_MOD_EN), 16'd1);
    ticks(3);

    // 0 -> 2 with absolute latency checks relative to acceptance cycle t0.
    t0 = cyc;
    request(2'd2);
    chk("gate_en_low", 16'(bus.CLK_MOD_EN), 16'd0);
    ticks(S);
    chk("sel2_switched", 16'({bus.CLK_MOD_PHASE_SEL2, bus.CLK_MOD_PHASE_SEL1}), 16'b10);
    ticks(S - 1);
    chk("switch_en_low", 16'(bus.CLK_MOD_EN), 16'd0);
    tick();
    chk("done_cycle", 16'(cyc - t0), 16'(1 + 2 * S));
    chk("done_pulse", 16'({bus.CLK_MOD_EN, bus.SWITCH_DONE}), 16'b11);
    tick();
    chk("ready_again", 16'(bus.PHASE_REQ_READY), 16'd1);
    ticks(2);

    // Sweep from phase 3 with dwell 5, through a full wrap.
    request(2'd3);
    ticks(2 * S + 3);
    bus.DWELL_CYCLES = 16'd5;
    bus.SWEEP_EN     = 1'b1;
    ticks(5 * (5 + 2 * S + 1) + 3);
    bus.SWEEP_EN = 1'b0;
    ticks(2 * S + 4);

    // Request coinciding with a sweep step, then a VALID pulse during GATE.
    request(2'd0);
    ticks(2 * S + 3);
    bus.SWEEP_EN = 1'b1;
    ticks(4);
    request(2'd1);
    tick();
    request(2'd3);
    ticks(20);
    bus.SWEEP_EN = 1'b0;
    ticks(2 * S + 4);

    // Reset on the third SWITCH cycle of a 0 -> 3 change.
    request(2'd0);
    ticks(2 * S + 3);
    request(2'd3);
    ticks(S + 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_phase", 16'(bus.PHASE_CUR), 16'd0);
    chk("abort_done",  16'(bus.SWITCH_DONE), 16'd0);
    chk("abort_en",    16'(bus.CLK_MOD_EN), 16'd1);
    chk("abort_ready", 16'(bus.PHASE_REQ_READY), 16'd1);
    ticks(3);

    // Zero dwell holds the sweep.
    bus.DWELL_CYCLES = '0;
    bus.SWEEP_EN     = 1'b1;
    ticks(100);
    chk("dwell0_phase", 16'(bus.PHASE_CUR), 16'd0);
    bus.SWEEP_EN = 1'b0;

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      bus.PHASE_REQ       = 2'($urandom_range(0, 3));
      bus.PHASE_REQ_VALID = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 60) == 0) bus.SWEEP_EN = ~bus.SWEEP_EN;
      if (!bus.SWEEP_EN && $urandom_range(0, 20) == 0)
        bus.DWELL_CYCLES = 16'($urandom_range(0, 7));
      rst = ($urandom_range(0, 250) == 0);
      tick();
    end
    rst = 1'b0;
    bus.PHASE_REQ_VALID = 1'b0;
    ticks(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
